// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package pipe_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    localparam logic [31:0] BUS_ERR_DATA     = 32'hDEADBEEF;
    localparam int unsigned MAX_WAIT_DEFAULT = 15;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pipe_reg_wb.sv
// MEM/WB pipeline register; a bubble (or reset) loads all-zero fields.
module pipe_reg_wb (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_bubble,
    input  logic        i_wreg,
    input  logic        i_m2reg,
    input  logic [31:0] i_mo,
    input  logic [31:0] i_alu,
    input  logic [4:0]  i_rn,
    output logic        o_wreg,
    output logic        o_m2reg,
    output logic [31:0] o_mo,
    output logic [31:0] o_alu,
    output logic [4:0]  o_rn
);

    always_ff @(posedge clk) begin
        if (resetn || i_bubble) begin
            o_wreg  <= 1'b0;
            o_m2reg <= 1'b0;
            o_mo    <= 32'h0;
            o_alu   <= 32'h0;
            o_rn    <= 5'h0;
        end else begin
            o_wreg  <= i_wreg;
            o_m2reg <= i_m2reg;
            o_mo    <= i_mo;
            o_alu   <= i_alu;
            o_rn    <= i_rn;
        end
    end

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage: runs loads/stores over a req/ack bus with timeout and feeds MEM/WB.
// Define MEM_ALIGN_CHECK_EN to reject misaligned accesses via the align_err pulse.
module pipe_mem_stage
    import pipe_mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        bus_err,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        align_err,
`endif
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn
);

    localparam logic [7:0] W_MAX = 8'(MAX_WAIT);

    mem_state_e  r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdq;
    logic [7:0]  r_cnt;
    logic        r_err;

    logic        w_mem_op;
    logic        w_misalign;
    logic        w_start;
    logic [7:0]  w_cnt_inc;
    logic        w_timeout;
    logic        w_in_done;
    logic        w_bubble;
    logic        w_wb_wreg;
    logic        w_wb_m2reg;
    logic [31:0] w_wb_mo;

    assign w_mem_op = mm2reg | mwmem;

`ifdef MEM_ALIGN_CHECK_EN
    logic r_align_err;
    assign w_misalign = w_mem_op & (malu[1:0] != 2'b00);
    assign align_err  = r_align_err;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start   = w_mem_op & ~w_misalign;
    assign w_cnt_inc = sat_inc8(r_cnt);
    // The current ACCESS cycle is the MAX_WAIT-th one when the incremented count reaches it.
    assign w_timeout = (w_cnt_inc >= W_MAX);
    assign w_in_done = (r_state == DONE);

    assign stall = ((r_state == IDLE) && w_start) || (r_state == ACCESS);

    always_comb begin
        w_bubble   = stall | ((r_state == IDLE) & w_misalign);
        w_wb_wreg  = mwreg  & ~(w_in_done & r_err);
        w_wb_m2reg = mm2reg & ~(w_in_done & r_err);
        w_wb_mo    = 32'h0;
        if (w_in_done && mm2reg) begin
            w_wb_mo = r_rdq;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_rdq     <= 32'h0;
            r_cnt     <= 8'h0;
            r_err     <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_align_err <= 1'b0;
`endif
        end else begin
`ifdef MEM_ALIGN_CHECK_EN
            r_align_err <= 1'b0;
`endif
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= ACCESS;
                        r_req   <= 1'b1;
                        r_we    <= mwmem;
                        r_addr  <= {malu[31:2], 2'b00};
                        r_wdata <= mb;
                        r_cnt   <= 8'h0;
                    end
`ifdef MEM_ALIGN_CHECK_EN
                    else if (w_misalign) begin
                        r_align_err <= 1'b1;
                    end
`endif
                end
                ACCESS: begin
                    // An ack in the timeout cycle still completes normally.
                    if (mem_ack) begin
                        r_rdq   <= mem_rdata;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= DONE;
                    end else if (w_timeout) begin
                        r_rdq   <= BUS_ERR_DATA;
                        r_err   <= 1'b1;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                DONE: begin
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    // The error flag is only ever set for the single DONE cycle, so it doubles as the pulse.
    assign bus_err   = r_err;

    pipe_reg_wb u_reg_wb (
        .clk      (clk),
        .resetn   (resetn),
        .i_bubble (w_bubble),
        .i_wreg   (w_wb_wreg),
        .i_m2reg  (w_wb_m2reg),
        .i_mo     (w_wb_mo),
        .i_alu    (malu),
        .i_rn     (mrn),
        .o_wreg   (wwreg),
        .o_m2reg  (wm2reg),
        .o_mo     (wmo),
        .o_alu    (walu),
        .o_rn     (wrn)
    );

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Scoreboard bench for pipe_mem_stage: stimulus pushes expected MEM/WB results, a monitor pops them.
module tb_pipe_mem_stage;

    localparam int unsigned MW          = 4;
    localparam logic [31:0] ERR_DATA    = 32'hDEADBEEF;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [31:0] mo;
        logic [31:0] alu;
        logic [4:0]  rn;
    } wb_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb, mem_rdata;
    logic [4:0]  mrn;
    logic        mem_ack;
    logic        mem_req, mem_we, stall, bus_err, wwreg, wm2reg;
    logic [31:0] mem_addr, mem_wdata, wmo, walu;
    logic [4:0]  wrn;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int  n_tests = 0;
    int  n_fail  = 0;
    wb_t exp_q[$];

    always #5 clk = ~clk;

    pipe_mem_stage #(.MAX_WAIT(MW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mwmem     (mwmem),
        .malu      (malu),
        .mb        (mb),
        .mrn       (mrn),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .bus_err   (bus_err),
`ifdef MEM_ALIGN_CHECK_EN
        .align_err (align_err),
`endif
        .wwreg     (wwreg),
        .wm2reg    (wm2reg),
        .wmo       (wmo),
        .walu      (walu),
        .wrn       (wrn)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic nop();
        mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
        malu = 32'h0; mb = 32'h0; mrn = 5'h0;
    endtask

    task automatic alu_op(input logic wr, input logic [31:0] a, input logic [4:0] rn);
        wb_t e;
        mwreg = wr; mm2reg = 1'b0; mwmem = 1'b0; malu = a; mrn = rn;
        e.wreg = wr; e.m2reg = 1'b0; e.mo = 32'h0; e.alu = a; e.rn = rn;
        exp_q.push_back(e);
        @(negedge clk);
        chk("alu_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        nop();
    endtask

    // w < 0 means the bus never acknowledges.
    task automatic mem_op(input logic ld, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rn, input int w, input logic [31:0] rd);
        wb_t e;
        int  c = 0;
        int  n_stall = 0;
        int  n_req = 0;
        bit  done = 1'b0;
        mwreg = ld; mm2reg = ld; mwmem = !ld; malu = addr; mb = wd; mrn = rn;
        e.wreg  = ld && (w >= 0);
        e.m2reg = ld && (w >= 0);
        e.mo    = !ld ? 32'h0 : ((w >= 0) ? rd : ERR_DATA);
        e.alu   = addr;
        e.rn    = rn;
        exp_q.push_back(e);
        while (!done && c < 64) begin
            mem_ack   = (c >= 1) && (c - 1 == w);
            mem_rdata = mem_ack ? rd : 32'h0BAD0BAD;
            @(negedge clk);
            if (stall) n_stall++;
            if (mem_req) begin
                n_req++;
                chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
                chk("mem_we", {31'h0, mem_we}, {31'h0, !ld});
                chk("mem_wdata", mem_wdata, wd);
            end
            if (!stall && c > 0) begin
                chk("req_low_in_done", {31'h0, mem_req}, 32'h0);
                chk("bus_err_in_done", {31'h0, bus_err}, {31'h0, (w < 0)});
                done = 1'b1;
            end
            @(posedge clk); #1;
            c++;
        end
        mem_ack = 1'b0;
        chk("stall_cycles", n_stall, (w < 0) ? 1 + MW : 2 + w);
        chk("req_cycles", n_req, (w < 0) ? MW : w + 1);
        nop();
    endtask

    // Monitor: MEM/WB must be a bubble after a stall cycle; any non-bubble is a result to score.
    initial begin : monitor
        logic prev_stall = 1'b0;
        logic any;
        wb_t  e;
        forever begin
            @(negedge clk);
            any = wwreg | wm2reg | (wmo != 0) | (walu != 0) | (wrn != 0);
            if (prev_stall === 1'b1) begin
                chk("wb_bubble", {31'h0, any}, 32'h0);
            end else if (any === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", walu, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_wwreg", {31'h0, wwreg}, {31'h0, e.wreg});
                    chk("wb_wm2reg", {31'h0, wm2reg}, {31'h0, e.m2reg});
                    chk("wb_wmo", wmo, e.mo);
                    chk("wb_walu", walu, e.alu);
                    chk("wb_wrn", {27'h0, wrn}, {27'h0, e.rn});
                end
            end
            prev_stall = stall;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stimulus
        resetn = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
        nop();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_wb", {wwreg, wm2reg, wrn} | wmo | walu, 32'h0);
        resetn = 1'b0;

        alu_op(1'b1, 32'h0000_1234, 5'd5);
        mem_op(1'b1, 32'h40, 32'h0, 5'd3, 2, 32'hCAFEF00D);
        mem_op(1'b0, 32'h80, 32'hA5A5A5A5, 5'd9, 0, 32'h0);
        // back-to-back loads, then ack landing in the timeout cycle
        mem_op(1'b1, 32'h44, 32'h0, 5'd4, 0, 32'h11112222);
        mem_op(1'b1, 32'h48, 32'h0, 5'd6, 1, 32'h33334444);
        mem_op(1'b1, 32'h50, 32'h0, 5'd8, MW - 1, 32'h55556666);

        mem_op(1'b1, 32'h200, 32'h0, 5'd10, -1, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        chk("late_ack_req", {31'h0, mem_req}, 32'h0);
        chk("bus_err_once", {31'h0, bus_err}, 32'h0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        mem_op(1'b1, 32'h60, 32'h0, 5'd12, 0, 32'h00000009);

        // reset in the second ACCESS cycle; no write-back expected
        mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0; malu = 32'h100; mrn = 5'd7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
        resetn = 1'b1;
        nop();
        @(posedge clk); #1;
        chk("rst_acc_req", {31'h0, mem_req}, 32'h0);
        chk("rst_acc_stall", {31'h0, stall}, 32'h0);
        chk("rst_acc_out", {mem_we, bus_err, wwreg, wm2reg, wrn} | mem_addr | mem_wdata
                           | wmo | walu, 32'h0);
        resetn = 1'b0;
        alu_op(1'b1, 32'h0000_ABCD, 5'd31);

`ifdef MEM_ALIGN_CHECK_EN
        mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0; malu = 32'h42; mrn = 5'd14;
        @(negedge clk);
        chk("align_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        nop();
        @(negedge clk);
        chk("align_err_pulse", {31'h0, align_err}, 32'h1);
        chk("align_req", {31'h0, mem_req}, 32'h0);
        chk("align_wwreg", {31'h0, wwreg}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("align_err_clear", {31'h0, align_err}, 32'h0);
        @(posedge clk); #1;
`else
        mem_op(1'b1, 32'h46, 32'h0, 5'd13, 0, 32'h00000077);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_mem_stage.md
# pipe_mem_stage

MEM stage of the five-stage pipeline. It takes the EX/MEM register outputs, runs loads and stores over a request/acknowledge data-memory bus with variable latency, and stalls the front of the pipe while an access is in flight. It also holds the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- MAX_WAIT, 15: number of ACCESS cycles without mem_ack before the access is abandoned as a bus error (1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset; synchronous, active-high.
- mwreg  in  1  register-write enable of the instruction in MEM.
- mm2reg  in  1  load (result taken from memory).
- mwmem  in  1  store.
- malu  in  32  ALU result; the memory address for loads and stores.
- mb  in  32  store data.
- mrn  in  5  destination register number.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr  out  32  word address, registered.
- mem_wdata  out  32  write data, registered.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_ack  in  1  one-cycle completion pulse.
- stall  out  1  combinational; holds the PC, IF/ID, ID/EX and EX/MEM registers.
- bus_err  out  1  one-cycle pulse when an access times out.
- wwreg, wm2reg  out  1 each  MEM/WB control outputs.
- wmo  out  32  MEM/WB load data.
- walu  out  32  MEM/WB ALU result.
- wrn  out  5  MEM/WB destination register.

## Operation
States:
- IDLE
  - If mm2reg|mwmem: stall=1. Next state is ACCESS. Register mem_req=1, mem_addr={malu[31:2],2'b00}, mem_wdata=mb, mem_we=mwmem.
  - Otherwise: stall=0, and the MEM/WB register loads {mwreg, mm2reg, 0, malu, mrn}.
- ACCESS
  - stall=1. mem_req, mem_addr, mem_wdata and mem_we are held stable.
  - On mem_ack: capture mem_rdata into rdq, drop mem_req, go to DONE.
  - If the wait counter reaches MAX_WAIT without mem_ack: drop mem_req, set rdq=32'hDEADBEEF, set the error flag, pulse bus_err, go to DONE.
- DONE
  - stall=0. The MEM/WB register loads {mwreg & ~err, mm2reg & ~err, rdq, malu, mrn}.
  - Clear the error flag. Next state is IDLE.
- On every stall=1 cycle, the MEM/WB register loads a bubble: all fields zero.
- For stores, wmo=0.
- mem_ack outside ACCESS is ignored.
- mem_ack arriving in the same cycle the counter hits MAX_WAIT counts as success; ack wins.
- The wait counter is 8 bits. It clears on entry to ACCESS and saturates; it never wraps.

## Timing
- Reset value of every output is 0, the state is IDLE, and the counter is 0.
- Reset during ACCESS drops mem_req on the same edge. No completion is written back.
- Non-memory instruction: 1 cycle, no stall.
- Memory instruction whose ack arrives w cycles after mem_req rises (w=0 means ack in the first ACCESS cycle):
  - stall is high for 2+w cycles.
  - The result appears on the MEM/WB outputs at the end of the DONE cycle.
- Timeout: stall is high for 1+MAX_WAIT cycles, then DONE.
- Back-to-back memory instructions:
  - The next one is seen in IDLE on the cycle after DONE.
  - mem_req is low for at least one cycle between them.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A memory op in IDLE with malu[1:0]!=0 issues no bus request and does not stall.
  - It pulses align_err (an extra 1-bit output, reset 0).
  - The MEM/WB register loads a bubble.
- MEM_ALIGN_CHECK_EN undefined:
  - The align_err port is absent.
  - malu[1:0] are ignored, and the access goes to the aligned word.

## Structure
- Package pipe_mem_pkg holds:
  - state enum {IDLE, ACCESS, DONE};
  - BUS_ERR_DATA = 32'hDEADBEEF;
  - default MAX_WAIT.
- Sub-module pipe_reg_wb holds the MEM/WB register. It has clk, resetn, a load/bubble select, the five fields in and the five fields out.

## Test plan
- ALU op, malu=0x1234, mrn=5, mwreg=1 -> next cycle walu=0x1234, wrn=5, wwreg=1, stall never high.
- Load from 0x40, mem_ack on the 3rd ACCESS cycle with rdata=0xCAFEF00D -> stall high 4 cycles; wmo=0xCAFEF00D, wm2reg=1, wwreg=1; bubbles on the MEM/WB outputs meanwhile.
- Store 0xA5A5A5A5 to 0x80, ack with w=0 -> mem_we=1, mem_addr=0x80, mem_wdata=0xA5A5A5A5 held until ack; stall high 2 cycles; wmo=0.
- Load with MAX_WAIT=4 and no ack -> bus_err pulses once; mem_req low after 4 ACCESS cycles; wwreg=0; a late mem_ack is ignored.
- resetn asserted in the 2nd ACCESS cycle -> next edge: mem_req=0, stall=0, all outputs 0, state IDLE.
- MEM_ALIGN_CHECK_EN, load from 0x42 -> align_err=1 for one cycle, mem_req stays 0, wwreg=0, no stall.
